// File: rtl/sys_defs.sv
// Shared types for the RV32M multiply functional unit and its neighbours.
package sys_defs;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned PR_IDX_WIDTH  = 6;
  localparam int unsigned ROB_IDX_WIDTH = 5;

  typedef logic [PR_IDX_WIDTH-1:0]  PRN;
  typedef logic [ROB_IDX_WIDTH-1:0] ROB_IDX;

  typedef enum logic [1:0] {
    MULT   = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  typedef struct packed {
    MULT_FUNC mult;
  } OP_SEL;

  typedef struct packed {
    logic            valid;
    logic            halt;
    PRN              dest_pr;
    ROB_IDX          rob_entry;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    OP_SEL           op_sel;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic            valid;
    logic            halt;
    PRN              dest_pr;
    ROB_IDX          rob_entry;
    logic [XLEN-1:0] dest_value;
  } FU_COMPLETE_PACKET;

  // Per-op bookkeeping that rides alongside the datapath.
  typedef struct packed {
    logic     valid;
    logic     halt;
    PRN       dest_pr;
    ROB_IDX   rob_entry;
    MULT_FUNC func;
  } MULT_META;

  // Widen an operand to the full product width, sign- or zero-extending.
  function automatic logic [2*XLEN-1:0] extend_operand(input logic [XLEN-1:0] value,
                                                       input logic is_signed);
    return {{XLEN{is_signed & value[XLEN-1]}}, value};
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One partial-product stage: folds BITS multiplier bits into the running sum.
module mult_pipe_stage
  import sys_defs::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic [2*XLEN-1:0] in_mcand,
  input  logic [2*XLEN-1:0] in_mplier,
  input  logic [2*XLEN-1:0] in_sum,
  input  MULT_META          in_meta,
  output logic [2*XLEN-1:0] out_mcand,
  output logic [2*XLEN-1:0] out_mplier,
  output logic [2*XLEN-1:0] out_sum,
  output MULT_META          out_meta
);

  logic     valid_q;
  logic     halt_q;
  PRN       dest_pr_q;
  ROB_IDX   rob_entry_q;
  MULT_FUNC func_q;

  logic [2*XLEN-1:0] mplier_slice;

  // Low multiplier bits for this stage, zero-extended to product width.
  always_comb begin
    mplier_slice = {{(2*XLEN-BITS){1'b0}}, in_mplier[BITS-1:0]};
  end

  // Datapath advances every edge; no reset needed since valid gates everything.
  always_ff @(posedge clock) begin
    out_mcand   <= in_mcand << BITS;
    out_mplier  <= in_mplier >> BITS;
    out_sum     <= in_sum + in_mcand * mplier_slice;
    halt_q      <= in_meta.halt;
    dest_pr_q   <= in_meta.dest_pr;
    rob_entry_q <= in_meta.rob_entry;
    func_q      <= in_meta.func;
  end

  // Valid bit: async reset, synchronous flush on squash.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_meta.valid & ~squash;
    end
  end

  // Reassemble the meta record for the next stage.
  always_comb begin
    out_meta.valid     = valid_q;
    out_meta.halt      = halt_q;
    out_meta.dest_pr   = dest_pr_q;
    out_meta.rob_entry = rob_entry_q;
    out_meta.func      = func_q;
  end

endmodule

// File: rtl/fu_mult_pipe.sv
// Fully pipelined RV32M multiplier with an in-order output buffer and credit-based ready.
module fu_mult_pipe
  import sys_defs::*;
#(
  parameter int unsigned NUM_STAGE = 4,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              complete_stall,
  input  ISSUE_FU_PACKET    fu_packet_in,
  output logic              fu_ready,
  output logic              want_to_complete,
  output FU_COMPLETE_PACKET fu_packet_out
);

  localparam int unsigned BITS  = (2 * XLEN) / NUM_STAGE;
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  if (NUM_STAGE < 2 || ((2 * XLEN) % NUM_STAGE) != 0 || OUT_DEPTH < 1) begin : gen_bad_param
    $error("fu_mult_pipe: illegal NUM_STAGE/OUT_DEPTH");
  end

  logic [2*XLEN-1:0] mcand  [NUM_STAGE+1];
  logic [2*XLEN-1:0] mplier [NUM_STAGE+1];
  logic [2*XLEN-1:0] sum    [NUM_STAGE+1];
  MULT_META          meta   [NUM_STAGE+1];
  logic [NUM_STAGE-1:0] stage_valids;

  FU_COMPLETE_PACKET buf_q [OUT_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, occupancy_q;

  logic              accept, push, pop;
  logic              rs1_signed, rs2_signed;
  MULT_META          last_meta;
  FU_COMPLETE_PACKET push_pkt;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Credit check and handshake decode.
  always_comb begin
    fu_ready         = (occupancy_q < CNT_W'(OUT_DEPTH));
    want_to_complete = (count_q != '0);
    accept           = fu_packet_in.valid & fu_ready & ~squash;
    pop              = want_to_complete & ~complete_stall;
  end

  // Stage-0 inputs: operand extension depends on func alone.
  always_comb begin
    rs1_signed          = (fu_packet_in.op_sel.mult != MULHU);
    rs2_signed          = (fu_packet_in.op_sel.mult == MULT) ||
                          (fu_packet_in.op_sel.mult == MULH);
    mcand[0]            = extend_operand(fu_packet_in.rs1_value, rs1_signed);
    mplier[0]           = extend_operand(fu_packet_in.rs2_value, rs2_signed);
    sum[0]              = '0;
    meta[0].valid       = accept;
    meta[0].halt        = fu_packet_in.halt;
    meta[0].dest_pr     = fu_packet_in.dest_pr;
    meta[0].rob_entry   = fu_packet_in.rob_entry;
    meta[0].func        = fu_packet_in.op_sel.mult;
  end

  for (genvar k = 0; k < NUM_STAGE; k++) begin : gen_stage
    mult_pipe_stage #(
      .BITS (BITS)
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .squash     (squash),
      .in_mcand   (mcand[k]),
      .in_mplier  (mplier[k]),
      .in_sum     (sum[k]),
      .in_meta    (meta[k]),
      .out_mcand  (mcand[k+1]),
      .out_mplier (mplier[k+1]),
      .out_sum    (sum[k+1]),
      .out_meta   (meta[k+1])
    );
    assign stage_valids[k] = meta[k+1].valid;
  end

  // Final product selection for the op leaving the last stage.
  always_comb begin
    last_meta           = meta[NUM_STAGE];
    push                = last_meta.valid;
    push_pkt.valid      = 1'b1;
    push_pkt.halt       = last_meta.halt;
    push_pkt.dest_pr    = last_meta.dest_pr;
    push_pkt.rob_entry  = last_meta.rob_entry;
    push_pkt.dest_value = (last_meta.func == MULT) ? sum[NUM_STAGE][XLEN-1:0]
                                                   : sum[NUM_STAGE][2*XLEN-1:XLEN];
  end

  // Buffer storage: written on push, never reset.
  always_ff @(posedge clock) begin
    if (push && !squash) begin
      buf_q[tail_q] <= push_pkt;
    end
  end

  // Pointers, buffer count and credit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      occupancy_q <= '0;
    end else if (squash) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      occupancy_q <= '0;
    end else begin
      if (push) tail_q <= wrap_inc(tail_q);
      if (pop)  head_q <= wrap_inc(head_q);
      count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
      occupancy_q <= occupancy_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Head result, all-zero when the buffer is empty.
  always_comb begin
    fu_packet_out = '0;
    if (want_to_complete) begin
      fu_packet_out = buf_q[head_q];
    end
  end

  a_occupancy : assert property (@(posedge clock) disable iff (reset)
    int'(occupancy_q) == $countones(stage_valids) + int'(count_q));

  a_out_valid : assert property (@(posedge clock) disable iff (reset)
    fu_packet_out.valid == want_to_complete);

  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    !(push && !squash && !pop && count_q == CNT_W'(OUT_DEPTH)));

endmodule

// File: tb/tb_fu_mult_pipe.sv
// Directed and randomized checks for fu_mult_pipe.
module tb_fu_mult_pipe;
  import sys_defs::*;

  typedef struct {
    MULT_FUNC    f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    FU_COMPLETE_PACKET pkt;
    int                avail;
  } exp_t;

  int n_pass  = 0;
  int n_total = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Directed DUT with OUT_DEPTH=2 and a deeper one for full-throughput sequences.
  logic reset, squash, stall, ready, want;
  ISSUE_FU_PACKET pin;
  FU_COMPLETE_PACKET pout;
  logic squash4, stall4, ready4, want4;
  ISSUE_FU_PACKET pin4;
  FU_COMPLETE_PACKET pout4;

  fu_mult_pipe #(.NUM_STAGE(4), .OUT_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .squash(squash), .complete_stall(stall),
    .fu_packet_in(pin), .fu_ready(ready), .want_to_complete(want), .fu_packet_out(pout)
  );

  fu_mult_pipe #(.NUM_STAGE(4), .OUT_DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .squash(squash4), .complete_stall(stall4),
    .fu_packet_in(pin4), .fu_ready(ready4), .want_to_complete(want4), .fu_packet_out(pout4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference multiply straight from the RV32M definitions.
  function automatic logic [31:0] ref_mult(input MULT_FUNC f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    case (f)
      MULT: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[31:0]; end
      MULH: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      MULHSU: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
      default: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
    endcase
  endfunction

  function automatic ISSUE_FU_PACKET mkop(input MULT_FUNC f, input logic [31:0] a,
                                          input logic [31:0] b, input PRN pr,
                                          input ROB_IDX rob, input logic h);
    ISSUE_FU_PACKET op;
    op             = '0;
    op.valid       = 1'b1;
    op.halt        = h;
    op.dest_pr     = pr;
    op.rob_entry   = rob;
    op.rs1_value   = a;
    op.rs2_value   = b;
    op.op_sel.mult = f;
    return op;
  endfunction

  function automatic FU_COMPLETE_PACKET model(input ISSUE_FU_PACKET op);
    FU_COMPLETE_PACKET p;
    p            = '0;
    p.valid      = 1'b1;
    p.halt       = op.halt;
    p.dest_pr    = op.dest_pr;
    p.rob_entry  = op.rob_entry;
    p.dest_value = ref_mult(op.op_sel.mult, op.rs1_value, op.rs2_value);
    return p;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Randomized configurations, each with its own scoreboard.
  for (genvar g = 0; g < 6; g++) begin : gen_rnd
    localparam int unsigned NS = (g < 2) ? 2 : ((g < 4) ? 4 : 8);
    localparam int unsigned OD = (g % 2 == 1) ? 4 : 1;
    logic rst, sq, st, rdy, wnt;
    ISSUE_FU_PACKET    rin;
    FU_COMPLETE_PACKET rout;
    bit done = 1'b0;

    fu_mult_pipe #(.NUM_STAGE(NS), .OUT_DEPTH(OD)) u_dut (
      .clock(clock), .reset(rst), .squash(sq), .complete_stall(st),
      .fu_packet_in(rin), .fu_ready(rdy), .want_to_complete(wnt), .fu_packet_out(rout)
    );

    initial begin
      exp_t q[$];
      exp_t e;
      logic exp_rdy, exp_want;
      int   cyc;
      rst = 1'b1; sq = 1'b0; st = 1'b0; rin = '0;
      repeat (3) @(posedge clock);
      #1 rst = 1'b0;
      cyc = 0;
      for (int n = 0; n < 400; n++) begin
        rin = mkop(MULT_FUNC'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                   PRN'($urandom), ROB_IDX'($urandom), 1'($urandom));
        rin.valid = ($urandom % 4) != 0;
        sq = ($urandom % 40) == 0;
        st = ($urandom % 3) == 0;
        @(negedge clock);
        exp_rdy  = q.size() < OD;
        exp_want = (q.size() > 0) && (q[0].avail <= cyc);
        check($sformatf("rnd%0d_ready c%0d", g, cyc), 64'(rdy), 64'(exp_rdy));
        check($sformatf("rnd%0d_want c%0d", g, cyc), 64'(wnt), 64'(exp_want));
        check($sformatf("rnd%0d_out c%0d", g, cyc), 64'(rout),
              exp_want ? 64'(q[0].pkt) : 64'd0);
        if (sq) begin
          q.delete();
        end else begin
          if (exp_want && !st) void'(q.pop_front());
          if (rin.valid && exp_rdy) begin
            e.pkt   = model(rin);
            e.avail = cyc + NS + 1;
            q.push_back(e);
          end
        end
        @(posedge clock);
        #1 cyc++;
      end
      rin = '0; sq = 1'b0; st = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    vec_t           tbl[5];
    ISSUE_FU_PACKET ops[12];
    int             first, seen;
    FU_COMPLETE_PACKET got;

    tbl[0] = '{MULT,   32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB};
    tbl[1] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2] = '{MULHSU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF};
    tbl[3] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[4] = '{MULT,   32'h0001_0000, 32'h0001_0000, 32'h0};

    reset = 1'b1; squash = 1'b0; stall = 1'b0; pin = '0;
    squash4 = 1'b0; stall4 = 1'b0; pin4 = '0;
    #2;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_want", 64'(want), 64'd0);
    check("reset_out", 64'(pout), 64'd0);
    check("reset_ready4", 64'(ready4), 64'd1);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;

    // Single MUL, latency and tags.
    pin = mkop(tbl[0].f, tbl[0].a, tbl[0].b, PRN'(7), ROB_IDX'(3), 1'b0);
    @(negedge clock);
    check("mul_ready", 64'(ready), 64'd1);
    @(posedge clock);
    #1 pin = '0;
    first = 0; got = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (want && first == 0) begin first = k; got = pout; end
    end
    check("mul_latency", 64'(first), 64'd5);
    check("mul_value", 64'(got.dest_value), 64'(tbl[0].exp));
    check("mul_pr", 64'(got.dest_pr), 64'd7);
    check("mul_rob", 64'(got.rob_entry), 64'd3);
    check("mul_drained", 64'(want), 64'd0);

    // Four back-to-back ops on the deeper instance.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1 pin4 = mkop(tbl[i+1].f, tbl[i+1].a, tbl[i+1].b, PRN'(20 + i), ROB_IDX'(8 + i), 1'b0);
      @(negedge clock);
      check($sformatf("b2b_ready%0d", i), 64'(ready4), 64'd1);
    end
    @(posedge clock);
    #1 pin4 = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      check($sformatf("b2b_want%0d", k), 64'(want4), 64'((k >= 1 && k <= 4) ? 1 : 0));
      if (k >= 1 && k <= 4) begin
        check($sformatf("b2b_value%0d", k - 1), 64'(pout4.dest_value), 64'(tbl[k].exp));
        check($sformatf("b2b_pr%0d", k - 1), 64'(pout4.dest_pr), 64'(20 + k - 1));
        check($sformatf("b2b_rob%0d", k - 1), 64'(pout4.rob_entry), 64'(8 + k - 1));
      end
    end

    // Long stall with continuous issue attempts on the OUT_DEPTH=2 instance.
    @(posedge clock);
    #1 stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ops[i] = mkop(MULT, 32'(i + 1), 32'd3, PRN'(10 + i), ROB_IDX'(i), 1'(i));
      pin = ops[i];
      @(negedge clock);
      check($sformatf("stall_ready%0d", i), 64'(ready), 64'((i < 2) ? 1 : 0));
      @(posedge clock);
      #1;
    end
    pin = '0; stall = 1'b0;
    @(negedge clock);
    check("stall_out0", 64'(pout), 64'(model(ops[0])));
    check("stall_ready_hold", 64'(ready), 64'd0);
    @(negedge clock);
    check("stall_out1", 64'(pout), 64'(model(ops[1])));
    check("stall_ready_free", 64'(ready), 64'd1);
    @(negedge clock);
    check("stall_empty", 64'(want), 64'd0);

    // Squash with three ops in flight, one buffered and a same-cycle issue.
    @(posedge clock);
    #1 stall4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pin4 = mkop(tbl[i+1].f, tbl[i+1].a, tbl[i+1].b, PRN'(40 + i), ROB_IDX'(16 + i), 1'b0);
      @(posedge clock);
      #1;
    end
    pin4 = '0;
    @(posedge clock);
    #1 pin4 = mkop(MULT, 32'd5, 32'd5, PRN'(50), ROB_IDX'(20), 1'b0);
    squash4 = 1'b1;
    @(negedge clock);
    check("sq_pre_ready", 64'(ready4), 64'd0);
    check("sq_pre_want", 64'(want4), 64'd1);
    @(posedge clock);
    #1 squash4 = 1'b0; pin4 = '0; stall4 = 1'b0;
    @(negedge clock);
    check("sq_want", 64'(want4), 64'd0);
    check("sq_ready", 64'(ready4), 64'd1);
    check("sq_out", 64'(pout4), 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (want4) seen++;
    end
    check("sq_no_results", 64'(seen), 64'd0);
    @(posedge clock);
    #1 pin4 = mkop(tbl[3].f, tbl[3].a, tbl[3].b, PRN'(33), ROB_IDX'(9), 1'b1);
    @(posedge clock);
    #1 pin4 = '0;
    first = 0; got = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (want4 && first == 0) begin first = k; got = pout4; end
    end
    check("sq_new_latency", 64'(first), 64'd5);
    check("sq_new_out", 64'(got), 64'(model(mkop(tbl[3].f, tbl[3].a, tbl[3].b, PRN'(33),
                                                 ROB_IDX'(9), 1'b1))));

    // Asynchronous reset mid-cycle with ops in flight.
    @(posedge clock);
    #1 pin = mkop(MULH, 32'h1234_5678, 32'h9ABC_DEF0, PRN'(1), ROB_IDX'(1), 1'b0);
    @(posedge clock);
    #1 pin = mkop(MULHU, 32'hDEAD_BEEF, 32'h2, PRN'(2), ROB_IDX'(2), 1'b0);
    @(posedge clock);
    #1 pin = '0;
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("areset_want", 64'(want), 64'd0);
    check("areset_out", 64'(pout), 64'd0);
    check("areset_ready", 64'(ready), 64'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (want) seen++;
    end
    check("areset_no_stale", 64'(seen), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      if (gen_rnd[0].done && gen_rnd[1].done && gen_rnd[2].done &&
          gen_rnd[3].done && gen_rnd[4].done && gen_rnd[5].done) break;
      @(posedge clock);
    end
    check("rnd_done", 64'(gen_rnd[0].done && gen_rnd[1].done && gen_rnd[2].done &&
                          gen_rnd[3].done && gen_rnd[4].done && gen_rnd[5].done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
